// File: rtl/branch_issue_scheduler.sv
// Branch reservation-station scheduler: collapsing queue (slot 0 oldest),
// CDB wakeup with same-cycle dispatch bypass, oldest-ready select and a
// registered one-op-per-cycle issue port toward branch_FU.
module branch_issue_scheduler #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 4,
  parameter int TAG_W   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           disp_valid,
  output logic                           disp_ready,
  input  logic [2:0]                     disp_branch_type,
  input  logic [TAG_W-1:0]               disp_rob_tag,
  input  logic                           disp_rs1_rdy,
  input  logic                           disp_rs2_rdy,
  input  logic [XLEN-1:0]                disp_rs1_val,
  input  logic [XLEN-1:0]                disp_rs2_val,
  input  logic [TAG_W-1:0]               disp_rs1_tag,
  input  logic [TAG_W-1:0]               disp_rs2_tag,
  input  logic                           cdb_valid,
  input  logic [TAG_W-1:0]               cdb_tag,
  input  logic [XLEN-1:0]                cdb_data,
  input  logic                           flush,
  output logic                           fu_valid_in,
  output logic [2:0]                     fu_branch_type,
  output logic [XLEN-1:0]                fu_rs1,
  output logic [XLEN-1:0]                fu_rs2,
  output logic [TAG_W-1:0]               fu_rob_tag,
  output logic [$clog2(ENTRIES+1)-1:0]   occupancy
);

  localparam int OCC_W = $clog2(ENTRIES + 1);
  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic [2:0]       btype;
    logic [TAG_W-1:0] rob_tag;
    logic             rs1_rdy;
    logic [XLEN-1:0]  rs1_val;
    logic [TAG_W-1:0] rs1_tag;
    logic             rs2_rdy;
    logic [XLEN-1:0]  rs2_val;
    logic [TAG_W-1:0] rs2_tag;
  } entry_t;

  // Capture a broadcast result into any still-waiting source of a valid entry.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_W-1:0] ct,
                                  input logic [XLEN-1:0] cd);
    entry_t r;
    r = e;
    if (cv && e.valid && !e.rs1_rdy && (e.rs1_tag == ct)) begin
      r.rs1_rdy = 1'b1;
      r.rs1_val = cd;
    end
    if (cv && e.valid && !e.rs2_rdy && (e.rs2_tag == ct)) begin
      r.rs2_rdy = 1'b1;
      r.rs2_val = cd;
    end
    return r;
  endfunction

  entry_t              ent_q [ENTRIES];
  entry_t              ent_d [ENTRIES];
  entry_t              woke  [ENTRIES];
  entry_t              disp_ent;
  logic [ENTRIES-1:0]  slot_rdy;
  logic                issue;
  logic [IDX_W-1:0]    sel_idx;
  logic                disp_fire;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [OCC_W-1:0]    wr_idx;

  logic                fu_valid_q, fu_valid_d;
  logic [2:0]          fu_type_q, fu_type_d;
  logic [XLEN-1:0]     fu_rs1_q, fu_rs1_d;
  logic [XLEN-1:0]     fu_rs2_q, fu_rs2_d;
  logic [TAG_W-1:0]    fu_tag_q, fu_tag_d;

  // Per-slot readiness (from registered state only) and CDB-woken copy.
  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_slot
    assign slot_rdy[gi] = ent_q[gi].valid & ent_q[gi].rs1_rdy & ent_q[gi].rs2_rdy;
    assign woke[gi]     = wake(ent_q[gi], cdb_valid, cdb_tag, cdb_data);
  end

  // Oldest-ready select: scan from the top so the lowest index wins.
  always_comb begin
    issue   = |slot_rdy;
    sel_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (slot_rdy[i]) sel_idx = IDX_W'(i);
    end
  end

  // Dispatch acceptance and the incoming entry, including CDB bypass.
  always_comb begin
    disp_ready = rst && !flush && (occ_q < OCC_W'(ENTRIES));
    disp_fire  = disp_valid && disp_ready;
    wr_idx     = occ_q - OCC_W'(issue);

    disp_ent          = '0;
    disp_ent.valid    = 1'b1;
    disp_ent.btype    = disp_branch_type;
    disp_ent.rob_tag  = disp_rob_tag;
    disp_ent.rs1_tag  = disp_rs1_tag;
    disp_ent.rs2_tag  = disp_rs2_tag;
    disp_ent.rs1_rdy  = disp_rs1_rdy || (cdb_valid && (cdb_tag == disp_rs1_tag));
    disp_ent.rs1_val  = disp_rs1_rdy ? disp_rs1_val : cdb_data;
    disp_ent.rs2_rdy  = disp_rs2_rdy || (cdb_valid && (cdb_tag == disp_rs2_tag));
    disp_ent.rs2_val  = disp_rs2_rdy ? disp_rs2_val : cdb_data;
  end

  // Next queue state: wake, collapse over the issued slot, append, flush.
  always_comb begin
    for (int i = 0; i < ENTRIES - 1; i++) begin
      ent_d[i] = (issue && (i >= int'(sel_idx))) ? woke[i+1] : woke[i];
    end
    ent_d[ENTRIES-1] = issue ? entry_t'('0) : woke[ENTRIES-1];
    for (int i = 0; i < ENTRIES; i++) begin
      if (disp_fire && (wr_idx == OCC_W'(i))) ent_d[i] = disp_ent;
    end
    occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(issue);
    if (flush) begin
      for (int i = 0; i < ENTRIES; i++) ent_d[i] = '0;
      occ_d = '0;
    end
  end

  // Issue register contents; a flush cancels the op selected this cycle.
  always_comb begin
    fu_valid_d = issue && !flush;
    fu_type_d  = fu_type_q;
    fu_rs1_d   = fu_rs1_q;
    fu_rs2_d   = fu_rs2_q;
    fu_tag_d   = fu_tag_q;
    if (fu_valid_d) begin
      fu_type_d = ent_q[sel_idx].btype;
      fu_rs1_d  = ent_q[sel_idx].rs1_val;
      fu_rs2_d  = ent_q[sel_idx].rs2_val;
      fu_tag_d  = ent_q[sel_idx].rob_tag;
    end
  end

  // State registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= '0;
      occ_q      <= '0;
      fu_valid_q <= 1'b0;
      fu_type_q  <= '0;
      fu_rs1_q   <= '0;
      fu_rs2_q   <= '0;
      fu_tag_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) ent_q[i] <= ent_d[i];
      occ_q      <= occ_d;
      fu_valid_q <= fu_valid_d;
      fu_type_q  <= fu_type_d;
      fu_rs1_q   <= fu_rs1_d;
      fu_rs2_q   <= fu_rs2_d;
      fu_tag_q   <= fu_tag_d;
    end
  end

  assign fu_valid_in    = fu_valid_q;
  assign fu_branch_type = fu_type_q;
  assign fu_rs1         = fu_rs1_q;
  assign fu_rs2         = fu_rs2_q;
  assign fu_rob_tag     = fu_tag_q;
  assign occupancy      = occ_q;

endmodule

// File: tb/tb_branch_issue_scheduler.sv
// Scoreboard bench for branch_issue_scheduler: stimulus pushes expected
// issues (with required cycle), a negedge monitor pops and compares.
module tb_branch_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_branch_type;
  logic [5:0]  disp_rob_tag;
  logic        disp_rs1_rdy, disp_rs2_rdy;
  logic [31:0] disp_rs1_val, disp_rs2_val;
  logic [5:0]  disp_rs1_tag, disp_rs2_tag;
  logic        cdb_valid;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        flush;
  logic        fu_valid_in;
  logic [2:0]  fu_branch_type;
  logic [31:0] fu_rs1, fu_rs2;
  logic [5:0]  fu_rob_tag;
  logic [2:0]  occupancy;

  branch_issue_scheduler #(.XLEN(32), .ENTRIES(4), .TAG_W(6)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_branch_type(disp_branch_type), .disp_rob_tag(disp_rob_tag),
    .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
    .disp_rs1_val(disp_rs1_val), .disp_rs2_val(disp_rs2_val),
    .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .fu_valid_in(fu_valid_in), .fu_branch_type(fu_branch_type),
    .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_rob_tag(fu_rob_tag),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0]  ty;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [5:0]  tag;
    int          at;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("[TB] check %s = %0h ok (cycle %0d)", name, act, cyc);
    end
  endtask

  task automatic push(input logic [2:0] ty, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [5:0] tag, input int at);
    exp_t e;
    e.ty = ty; e.r1 = r1; e.r2 = r2; e.tag = tag; e.at = at;
    sbq.push_back(e);
  endtask

  // Monitor: every issue pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (fu_valid_in) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL unexpected_issue: got tag=%0h rs1=%0h rs2=%0h at cycle %0d, expected no issue",
                 fu_rob_tag, fu_rs1, fu_rs2, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        if (fu_branch_type !== e.ty || fu_rs1 !== e.r1 || fu_rs2 !== e.r2 ||
            fu_rob_tag !== e.tag || cyc != e.at) begin
          n_fail++;
          $display("[TB] FAIL issue: got type=%0h rs1=%0h rs2=%0h tag=%0h cyc=%0d, expected type=%0h rs1=%0h rs2=%0h tag=%0h cyc=%0d",
                   fu_branch_type, fu_rs1, fu_rs2, fu_rob_tag, cyc, e.ty, e.r1, e.r2, e.tag, e.at);
        end else begin
          $display("[TB] issue type=%0h rs1=%0h rs2=%0h tag=%0h cyc=%0d ok",
                   fu_branch_type, fu_rs1, fu_rs2, fu_rob_tag, cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic disp(input logic [2:0] ty, input logic [5:0] tg,
                      input logic r1r, input logic [31:0] r1v, input logic [5:0] r1t,
                      input logic r2r, input logic [31:0] r2v, input logic [5:0] r2t);
    disp_valid       = 1'b1;
    disp_branch_type = ty;
    disp_rob_tag     = tg;
    disp_rs1_rdy     = r1r;
    disp_rs1_val     = r1v;
    disp_rs1_tag     = r1t;
    disp_rs2_rdy     = r2r;
    disp_rs2_val     = r2v;
    disp_rs2_tag     = r2t;
  endtask

  task automatic cdb(input logic [5:0] tg, input logic [31:0] d);
    cdb_valid = 1'b1;
    cdb_tag   = tg;
    cdb_data  = d;
  endtask

  int t;

  initial begin
    rst = 1'b0;
    idle();
    disp(3'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 6'd0);
    disp_valid = 1'b0;
    cdb_tag = '0; cdb_data = '0;
    step(); step();

    // Reset state
    chk("rst_disp_ready", 64'(disp_ready), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_fu_valid", 64'(fu_valid_in), 64'd0);
    rst = 1'b1;
    #1;
    chk("rel_disp_ready", 64'(disp_ready), 64'd1);

    // Single ready dispatch: issue at t+2
    disp(3'd0, 6'd3, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 6'd0);
    t = cyc;
    push(3'd0, 32'd5, 32'd5, 6'd3, t + 2);
    step(); idle();
    chk("single_occ_t1", 64'(occupancy), 64'd1);
    step();
    chk("single_occ_t2", 64'(occupancy), 64'd0);
    step(); step();

    // Fill with four ops waiting on tag 9
    for (int i = 0; i < 4; i++) begin
      disp(3'(i), 6'(20 + i), 1'b0, 32'd0, 6'd9, 1'b1, 32'(i), 6'd0);
      step();
    end
    idle();
    chk("fill_occ", 64'(occupancy), 64'd4);
    chk("fill_ready", 64'(disp_ready), 64'd0);
    disp(3'd5, 6'd30, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 6'd0);
    step(); idle();
    chk("fill_reject_occ", 64'(occupancy), 64'd4);

    // Wakeup: four back-to-back issues in dispatch order
    cdb(6'd9, 32'h0000_ABCD);
    t = cyc;
    for (int i = 0; i < 4; i++) push(3'(i), 32'h0000_ABCD, 32'(i), 6'(20 + i), t + 2 + i);
    step(); idle();
    chk("wake_ready_before", 64'(disp_ready), 64'd0);
    step();
    chk("wake_ready_after", 64'(disp_ready), 64'd1);
    chk("wake_occ_after", 64'(occupancy), 64'd3);
    step(); step(); step(); step();
    chk("wake_drained", 64'(occupancy), 64'd0);

    // Out-of-order readiness: slot 1 first, slot 0 after tag 7
    t = cyc;
    disp(3'd1, 6'd40, 1'b0, 32'd0, 6'd7, 1'b1, 32'd1, 6'd0);
    step();
    disp(3'd2, 6'd41, 1'b1, 32'd2, 6'd0, 1'b1, 32'd3, 6'd0);
    step(); idle();
    chk("ooo_occ", 64'(occupancy), 64'd2);
    cdb(6'd7, 32'h77);
    push(3'd2, 32'd2, 32'd3, 6'd41, t + 3);
    push(3'd1, 32'h77, 32'd1, 6'd40, t + 4);
    step(); idle();
    step(); step(); step();

    // Both sources waiting on the same tag capture one broadcast
    t = cyc;
    disp(3'd3, 6'd42, 1'b0, 32'd0, 6'd15, 1'b0, 32'd0, 6'd15);
    step(); idle();
    cdb(6'd15, 32'h55);
    push(3'd3, 32'h55, 32'h55, 6'd42, t + 3);
    step(); idle();
    step(); step(); step();

    // Same-cycle bypass of rs2 from the CDB
    t = cyc;
    disp(3'd4, 6'd43, 1'b1, 32'h10, 6'd0, 1'b0, 32'd0, 6'd12);
    cdb(6'd12, 32'h40);
    push(3'd4, 32'h10, 32'h40, 6'd43, t + 2);
    step(); idle();
    step(); step(); step();

    // Flush with three held entries (one ready) plus a concurrent dispatch
    disp(3'd5, 6'd44, 1'b0, 32'd0, 6'd50, 1'b1, 32'd0, 6'd0);
    step();
    disp(3'd6, 6'd45, 1'b0, 32'd0, 6'd50, 1'b1, 32'd0, 6'd0);
    step();
    disp(3'd7, 6'd46, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 6'd0);
    step();
    chk("flush_pre_occ", 64'(occupancy), 64'd3);
    disp(3'd0, 6'd47, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9, 6'd0);
    cdb(6'd50, 32'h1);
    flush = 1'b1;
    #1;
    chk("flush_ready", 64'(disp_ready), 64'd0);
    step(); idle();
    chk("flush_occ", 64'(occupancy), 64'd0);
    chk("flush_fu_valid", 64'(fu_valid_in), 64'd0);
    cdb(6'd50, 32'h2);
    step(); idle();
    step(); step(); step();
    chk("flush_occ_later", 64'(occupancy), 64'd0);

    // Asynchronous reset kills a pending issue pulse
    disp(3'd1, 6'd50, 1'b1, 32'd8, 6'd0, 1'b1, 32'd9, 6'd0);
    step(); idle();
    step();
    rst = 1'b0;
    #1;
    chk("arst_fu_valid", 64'(fu_valid_in), 64'd0);
    chk("arst_fu_rs1", 64'(fu_rs1), 64'd0);
    chk("arst_occ", 64'(occupancy), 64'd0);
    chk("arst_ready", 64'(disp_ready), 64'd0);
    step(); step();

    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_issue_scheduler.md
# branch_issue_scheduler

Reservation-station scheduler that sits between the dispatch stage and `branch_FU` in the OoO engine. It buffers up to `ENTRIES` branch micro-ops, captures missing source operands from the common data bus (CDB), and issues the oldest fully-ready entry to `branch_FU`, at most one per cycle. A pipeline flush empties it.

## Interface
Parameters:
- `XLEN`, 32, operand width
- `ENTRIES`, 4, reservation-station depth (≥2)
- `TAG_W`, 6, ROB/physical tag width

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `disp_valid`  in  1  dispatch request
- `disp_ready`  out  1  scheduler can accept a micro-op this cycle
- `disp_branch_type`  in  3  branch_type passed through to `branch_FU`
- `disp_rob_tag`  in  TAG_W  destination ROB tag
- `disp_rs1_rdy` / `disp_rs2_rdy`  in  1  operand already available
- `disp_rs1_val` / `disp_rs2_val`  in  XLEN  operand value (valid when rdy)
- `disp_rs1_tag` / `disp_rs2_tag`  in  TAG_W  producer tag (used when not rdy)
- `cdb_valid`  in  1  result broadcast
- `cdb_tag`  in  TAG_W  broadcast tag
- `cdb_data`  in  XLEN  broadcast value
- `flush`  in  1  discard all held entries
- `fu_valid_in`  out  1  issue strobe to `branch_FU.valid_in`
- `fu_branch_type`  out  3  to `branch_FU.branch_type`
- `fu_rs1` / `fu_rs2`  out  XLEN  to `branch_FU.rs1` / `rs2`
- `fu_rob_tag`  out  TAG_W  tag travelling with the issued op
- `occupancy`  out  $clog2(ENTRIES+1)  valid entries held

## Operation
- Storage is a collapsing queue. Slot 0 is always the oldest entry. Valid entries are contiguous from slot 0.
- Dispatch: when `disp_valid && disp_ready`, write slot `occupancy - (issue this cycle ? 1 : 0)`.
- `disp_ready = rst && !flush && occupancy < ENTRIES`. The ready decision is based on pre-issue occupancy: a full queue rejects dispatch even in a cycle where it issues.
- Wakeup: each valid entry compares each non-ready source tag against `cdb_tag` when `cdb_valid`. On a match the entry latches `cdb_data` and sets that source ready.
- Same-cycle bypass: a dispatching source that is not ready and whose tag matches the CDB is written already ready, holding `cdb_data`.
- Select: the lowest-index valid entry with both sources ready is chosen. It is then removed, and all higher slots shift down by one in the same edge.
- Issue register: `fu_*` outputs are registered. `fu_valid_in` pulses for exactly one cycle per issued op. There is no backpressure because `branch_FU` accepts every cycle.
- Flush: synchronous. At the next edge all entries are cleared and `fu_valid_in` is 0. A dispatch or CDB event in the flush cycle is ignored.

## Timing
- While `rst` = 0, all outputs are 0: `disp_ready` 0, `fu_valid_in` 0, `fu_*` 0, `occupancy` 0. On `rst` deassert, `disp_ready` = 1 combinationally.
- Dispatch with both operands ready, accepted in cycle t:
  - the entry is selectable in t+1;
  - `fu_valid_in` is high in t+2 (2-cycle minimum latency).
- Wakeup latency:
  - CDB match in cycle t makes the entry selectable in t+1, so `fu_valid_in` rises in t+2.
  - A dispatch bypassed from the CDB in cycle t issues in t+2.
- Selection uses only state registered before the current edge. An entry never issues in the same cycle it becomes ready.
- Throughput is 1 issue per cycle. `occupancy` updates at the edge by +1 (dispatch), −1 (issue), 0 (both or neither), or resets to 0 (flush).
- Boundaries:
  - Empty queue: `fu_valid_in` = 0.
  - Full queue: `disp_ready` = 0.
  - Two sources of one entry matching the same CDB tag: both captured.
  - An entry leaving via issue ignores a CDB match in that cycle.
- Asynchronous `rst` assertion mid-operation clears everything immediately, including a pending `fu_valid_in`.

## Test plan
- Reset then single ready dispatch: release `rst` and dispatch `type=0`, `rs1=5`, `rs2=5`, `tag=3` at t. Required: `fu_valid_in` = 1 at t+2 only, with `fu_rs1=5`, `fu_rs2=5`, `fu_rob_tag=3`; `occupancy` 1 → 0.
- Fill and back-pressure: dispatch 4 ops whose rs1 waits on tag 9. Required: `occupancy=4`, `disp_ready=0`, and a 5th `disp_valid` is not accepted.
- Wakeup and ordering: after the fill scenario, broadcast `cdb_tag=9`, `cdb_data=0xABCD`. Required: 4 consecutive `fu_valid_in` pulses in dispatch order, each with `fu_rs1=0xABCD`; `disp_ready` returns to 1 after the first issue.
- Out-of-order readiness: slot 0 waits on tag 7 and slot 1 is ready. Required: slot 1 issues first. After `cdb_tag=7`, slot 0 issues next cycle+1.
- Same-cycle bypass: dispatch rs2 waiting on tag 12 while `cdb_valid` with `tag=12`, `data=0x40`. Required: issue at t+2 with `fu_rs2=0x40`.
- Flush: with 3 entries held plus a concurrent dispatch, assert `flush` for 1 cycle. Required: `occupancy=0` next cycle, no `fu_valid_in` afterwards, and the concurrent dispatch is dropped.
